// File: rtl/disp_mux.sv
// disp_mux: six-digit multiplexed common-anode 7-segment driver for the clock.
// Scans s_lsd..h_msd right to left and shows a snapshot of all six digits
// that only changes at frame boundaries, so the display never tears.
//
// Parameters:
//   SCAN_DIV     clock cycles each digit stays lit (>= 2)
//   BLINK_FRAMES frames per blink half-period (blink build only)
// Ports:
//   dmux_clock      system clock, rising edge
//   dmux_reset      asynchronous active-low reset
//   dmux_enable     1 = display on, 0 = all digits dark (scan keeps running)
//   dmux_h_msd/lsd  hour digits, BCD
//   dmux_m_msd/lsd  minute digits, BCD
//   dmux_s_msd/lsd  second digits, BCD
//   dmux_blink_mask {hours, minutes, seconds} fields to flash (blink build)
//   dmux_seg        segments {g,f,e,d,c,b,a}, active-low
//   dmux_an         digit anodes, active-low one-hot, bit0 = rightmost
//   dmux_frame      one-cycle pulse when a new snapshot is taken
// Build option: define DMUX_BLINK_EN to add the blink mask and frame counter.
module disp_mux #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic       dmux_clock,
   input  logic       dmux_reset,
   input  logic       dmux_enable,
   input  logic [1:0] dmux_h_msd,
   input  logic [3:0] dmux_h_lsd,
   input  logic [2:0] dmux_m_msd,
   input  logic [3:0] dmux_m_lsd,
   input  logic [2:0] dmux_s_msd,
   input  logic [3:0] dmux_s_lsd,
`ifdef DMUX_BLINK_EN
   input  logic [2:0] dmux_blink_mask,
`endif
   output logic [6:0] dmux_seg,
   output logic [5:0] dmux_an,
   output logic       dmux_frame
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0]  cnt;
   logic [2:0]     idx;
   logic [5:0][3:0] snap;
   logic [3:0]     cur;
   logic           tick;
   logic           take;
   logic           blank;

   assign tick = (cnt == CNT_LAST);
   assign take = tick && (idx == 3'd5);

   always_comb begin
      cur = 4'd0;
      unique case (idx)
         3'd0:    cur = snap[0];
         3'd1:    cur = snap[1];
         3'd2:    cur = snap[2];
         3'd3:    cur = snap[3];
         3'd4:    cur = snap[4];
         3'd5:    cur = snap[5];
         default: cur = 4'd0;
      endcase
   end

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

`ifdef DMUX_BLINK_EN
   localparam int BW = $clog2(2 * BLINK_FRAMES);

   localparam logic [BW-1:0] BLK_LAST = BW'(2 * BLINK_FRAMES - 1);
   localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_FRAMES);

   logic [BW-1:0] bcnt;
   logic [2:0]    smask;

   always_ff @(posedge dmux_clock or negedge dmux_reset) begin
      if (!dmux_reset) begin
         bcnt  <= '0;
         smask <= '0;
      end else if (take) begin
         bcnt  <= (bcnt == BLK_LAST) ? '0 : bcnt + 1'b1;
         smask <= dmux_blink_mask;
      end
   end

   // idx[2:1] selects the pair: 0 = seconds, 1 = minutes, 2 = hours
   always_comb begin
      blank = 1'b0;
      if (bcnt >= BLK_HALF) begin
         unique case (idx[2:1])
            2'd0:    blank = smask[0];
            2'd1:    blank = smask[1];
            2'd2:    blank = smask[2];
            default: blank = 1'b0;
         endcase
      end
   end
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge dmux_clock or negedge dmux_reset) begin
      if (!dmux_reset) begin
         cnt        <= '0;
         idx        <= '0;
         snap       <= '0;
         dmux_frame <= 1'b0;
         dmux_seg   <= 7'h7F;
         dmux_an    <= 6'h3F;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         dmux_frame <= take;
         if (take) begin
            snap[0] <= dmux_s_lsd;
            snap[1] <= {1'b0, dmux_s_msd};
            snap[2] <= dmux_m_lsd;
            snap[3] <= {1'b0, dmux_m_msd};
            snap[4] <= dmux_h_lsd;
            snap[5] <= {2'b00, dmux_h_msd};
         end
         // outputs follow index/snapshot by one cycle
         if (dmux_enable) begin
            dmux_an  <= ~(6'b000001 << idx);
            dmux_seg <= blank ? 7'h7F : decode(cur);
         end else begin
            dmux_an  <= 6'h3F;
            dmux_seg <= 7'h7F;
         end
      end
   end

endmodule

// File: tb/tb_disp_mux.sv
// tb_disp_mux: directed checks of scan order, frame coherence, invalid BCD,
// enable gating and asynchronous reset for disp_mux with SCAN_DIV = 4.
module tb_disp_mux;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] h_msd;
   logic [3:0] h_lsd;
   logic [2:0] m_msd;
   logic [3:0] m_lsd;
   logic [2:0] s_msd;
   logic [3:0] s_lsd;
   logic [6:0] seg;
   logic [5:0] an;
   logic       frame;
`ifdef DMUX_BLINK_EN
   logic [2:0] blink_mask = 3'b000;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   disp_mux #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .dmux_clock  (clk),
      .dmux_reset  (rst_n),
      .dmux_enable (en),
      .dmux_h_msd  (h_msd),
      .dmux_h_lsd  (h_lsd),
      .dmux_m_msd  (m_msd),
      .dmux_m_lsd  (m_lsd),
      .dmux_s_msd  (s_msd),
      .dmux_s_lsd  (s_lsd),
`ifdef DMUX_BLINK_EN
      .dmux_blink_mask (blink_mask),
`endif
      .dmux_seg    (seg),
      .dmux_an     (an),
      .dmux_frame  (frame)
   );

   // inputs of one frame and the segment codes expected for digits 0..5
   typedef struct packed {
      logic [1:0]      hm;
      logic [3:0]      hl;
      logic [2:0]      mm;
      logic [3:0]      ml;
      logic [2:0]      sm;
      logic [3:0]      sl;
      logic [5:0][6:0] exp_seg;
   } vec_t;

   localparam int NV = 5;
   vec_t tbl [NV];

   task automatic apply(input vec_t v);
      h_msd = v.hm;
      h_lsd = v.hl;
      m_msd = v.mm;
      m_lsd = v.ml;
      s_msd = v.sm;
      s_lsd = v.sl;
   endtask

   task automatic chk(input string nm, input logic [6:0] a_seg,
                      input logic [5:0] a_an, input logic a_fr,
                      input logic [6:0] e_seg, input logic [5:0] e_an,
                      input logic e_fr);
      total++;
      if (a_seg !== e_seg || a_an !== e_an || a_fr !== e_fr) begin
         bad++;
         $display("FAIL %s t=%0t got seg=%h an=%h frame=%b want seg=%h an=%h frame=%b",
                  nm, $time, a_seg, a_an, a_fr, e_seg, e_an, e_fr);
      end
   endtask

   // one frame starting right after a frame pulse; optionally swaps
   // the inputs while digit 2 is being scanned
   task automatic run_frame(input string nm, input logic [5:0][6:0] es,
                            input bit swap, input vec_t nxt);
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         chk(nm, seg, an, frame, es[i/4], ~(6'b000001 << (i/4)), i == 23);
         if (swap && i == 8)
            apply(nxt);
      end
   endtask

   initial begin
      logic [5:0][6:0] zeros;
      bit              en_cur;
      int              p;
      bit              seen;

      for (int k = 0; k < 6; k++)
         zeros[k] = 7'h40;

      // 23:59:47
      tbl[0] = '{2'd2, 4'd3, 3'd5, 4'd9, 3'd4, 4'd7,
                 {7'h24, 7'h30, 7'h12, 7'h10, 7'h19, 7'h78}};
      // 00:00:00
      tbl[1] = '{2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0,
                 {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
      // 12:34:5C, invalid seconds units
      tbl[2] = '{2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'hC,
                 {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h3F}};
      // 3F:7E:68, widest narrow fields and invalid codes
      tbl[3] = '{2'd3, 4'hF, 3'd7, 4'hE, 3'd6, 4'd8,
                 {7'h30, 7'h3F, 7'h78, 7'h3F, 7'h02, 7'h00}};
      // 01:06:19
      tbl[4] = '{2'd0, 4'd1, 3'd0, 4'd6, 3'd1, 4'd9,
                 {7'h40, 7'h79, 7'h40, 7'h02, 7'h79, 7'h10}};

      rst_n = 1'b0;
      en    = 1'b1;
      apply(tbl[0]);
      #23;
      chk("reset_hold", seg, an, frame, 7'h7F, 6'h3F, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      // nonzero inputs are already present, but 00:00:00 shows
      // until the first snapshot
      run_frame("pre_snap", zeros, 1'b0, tbl[0]);

      for (int v = 0; v < NV; v++)
         run_frame($sformatf("frame%0d", v), tbl[v].exp_seg,
                   v < NV - 1, tbl[(v < NV - 1) ? v + 1 : v]);

      // enable low for 30 edges spanning a frame boundary
      en_cur = 1'b1;
      for (int j = 1; j <= 72; j++) begin
         @(posedge clk); #1;
         p = (j - 1) % 24;
         chk("enable", seg, an, frame,
             en_cur ? tbl[NV-1].exp_seg[p/4] : 7'h7F,
             en_cur ? ~(6'b000001 << (p/4)) : 6'h3F,
             (j % 24) == 0);
         en = !(j >= 4 && j < 34);
         en_cur = en;
      end

      // async reset in the middle of a frame-pulse cycle
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst", seg, an, frame, 7'h7F, 6'h3F, 1'b0);
      @(negedge clk);
      chk("rst_held", seg, an, frame, 7'h7F, 6'h3F, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_first", seg, an, frame, 7'h40, 6'h3E, 1'b0);

      // first frame pulse after reset arrives within a bounded wait
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (frame) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL frame_timeout got no pulse want pulse within 40 cycles");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/disp_mux.md
Name: disp_mux

Overview:
- Downstream display stage of the clock: consumes the BCD hour, minute and second digits from the counter chain and drives a 6-digit multiplexed common-anode 7-segment display.
- Per-digit prescaler, rotating digit index, frame-coherent snapshot of all six digits, registered segment/anode outputs.
- Sits between the counter stages and the board pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is lit (>=2); frame period = 6*SCAN_DIV cycles
BLINK_FRAMES, 250, frames per blink half-period (used only with DMUX_BLINK_EN)

Ports:
dmux_clock  in  1  system clock, rising edge
dmux_reset  in  1  asynchronous, active-low reset
dmux_enable  in  1  1 = display on; 0 = all digits dark, scanning continues
dmux_h_msd  in  2  hours tens, BCD
dmux_h_lsd  in  4  hours units, BCD
dmux_m_msd  in  3  minutes tens, BCD
dmux_m_lsd  in  4  minutes units, BCD
dmux_s_msd  in  3  seconds tens, BCD
dmux_s_lsd  in  4  seconds units, BCD
dmux_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dmux_an  out  6  digit anodes, active-low one-hot; bit0 = rightmost
dmux_frame  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, dmux_reset=0):
  - Outputs: seg=7'h7F, an=6'h3F, frame=0.
  - Internal state: prescaler=0, index=0, snapshot=all zero, blink count=0.
  - Reset asserted mid-scan takes effect immediately, without waiting for a clock edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick = (count==SCAN_DIV-1); on tick, count returns to 0.
- Digit index 0..5, advances only on tick.
  - Wraps 5->0.
  - Mapping: 0=s_lsd, 1=s_msd, 2=m_lsd, 3=m_msd, 4=h_lsd, 5=h_msd.
- Snapshot:
  - On tick with index==5, all six inputs are registered into the snapshot and frame=1 for exactly that cycle.
  - Otherwise frame=0.
  - The displayed values change only at frame boundaries; no tearing across a frame.
  - Until the first snapshot after reset, the display shows 00:00:00.
- Outputs are registered one cycle after index and snapshot.
  - an = ~(1<<index) when enable=1; 6'h3F when enable=0.
  - seg = decode(snapshot[index]) when enable=1; 7'h7F when enable=0.
  - enable is sampled every cycle; prescaler, index and frame are unaffected by it.
- Narrow fields (2/3-bit) are zero-extended to 4 bits before decoding.
- Decode (hex, active-low), applied to the zero-extended 4-bit value:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values 10..15: dash = 3F (segment g only).
- No leading-zero blanking. No inter-digit dead time.

Optional Feature:
- Macro: DMUX_BLINK_EN
- Defined:
  - Adds input dmux_blink_mask[2:0]: bit0 = seconds, bit1 = minutes, bit2 = hours.
  - The mask is captured in the snapshot alongside the digits.
  - A frame counter runs 0..2*BLINK_FRAMES-1, incrementing on each frame pulse; it resets to 0.
  - While the counter >= BLINK_FRAMES (off phase), digits belonging to a masked pair output seg=7'h7F. The anode still cycles normally.
  - Used by the time-set controller to flash the field being edited.
- Not defined: port and counter are absent; behaviour is exactly as above.

Test Plan:
1. Reset: assert dmux_reset low mid-frame with SCAN_DIV=4 -> an=3F, seg=7F and frame=0 with no clock edge; after release, first edge gives an=3E, seg=40.
2. Scan order: SCAN_DIV=4, inputs 23:59:47 held, wait for first frame pulse -> an sequence 3E,3D,3B,37,2F,1F, each held 4 cycles, seg 78,19,10,12,30,24; frame pulse every 24 cycles.
3. Coherence: change inputs from 23:59:47 to 00:00:00 while index==2 -> remaining digits of that frame still show 23:59:47; new values appear from the cycle after the next frame pulse.
4. Invalid BCD: s_lsd=4'hC -> seg=3F while an=3E; other digits unaffected.
5. Enable: drop enable for 30 cycles -> an=3F, seg=7F for that span; frame still pulses at 24-cycle spacing; on re-enable, an resumes at the current index.
6. DMUX_BLINK_EN: BLINK_FRAMES=2, mask=3'b010 -> minute digits show normally in frames 0,1 and dark (seg=7F) in frames 2,3; hours and seconds always lit; sequence repeats every 4 frames.
